t05_fetch_pc_unit: RTL and testbench
====================================

Name: t05_fetch_pc_unit

Overview:
- Parametrised successor to the team's PC register: owns the program counter and fetches from instruction memory over a req/ack handshake.
- Presents instructions to decode over a valid/ready handshake.
- Computes branch, JAL and JALR targets internally; reports link address and misaligned-target faults.
- Sits between the instruction memory port and decode/ALU. The ALU supplies only branch_taken.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, PC value after reset
OFFSET_SHIFT, 0, left shift applied to imm for BRANCH/JAL (0 = byte offsets, 2 = legacy word offsets)
ALIGN_CHECK, 1, 1 = trap on redirect target with target[1:0] != 0; 0 = force target[1:0] to 0 silently

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
en  in  1  run enable; fetching starts and continues only while high
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, equals pc while imem_req is high
imem_ack  in  1  one-cycle pulse: imem_rdata valid and request retired
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr_ready  in  1  decode accepts instr this cycle (low = stall)
instr  out  32  instruction word
instr_pc  out  XLEN  address of instr
redirect_valid  in  1  one-cycle redirect request from execute
redirect_kind  in  2  BRANCH=0, JAL=1, JALR=2, 3 reserved (ignored)
redirect_pc  in  XLEN  pc of the redirecting instruction
branch_taken  in  1  BRANCH condition result from ALU
imm  in  XLEN  sign-extended immediate
rs1_val  in  XLEN  rs1 value for JALR
link_addr  out  XLEN  redirect_pc + 4 (combinational, for rd write)
misalign_err  out  1  sticky fault flag

Behaviour:
- Reset (async): pc = RESET_VECTOR; state IDLE; imem_req, instr_valid and misalign_err = 0; instr and instr_pc = 0; pending-redirect flag cleared.
- Reset mid-fetch abandons the outstanding request. Memory must tolerate an abandoned request.
- Target calculation (combinational):
  - BRANCH and JAL: redirect_pc + (imm << OFFSET_SHIFT).
  - JALR: (rs1_val + imm) & ~1.
  - All sums are modulo 2^XLEN; no overflow flag.
- Effective redirect: redirect_valid AND (kind == JAL, OR kind == JALR, OR (kind == BRANCH AND branch_taken)). Kind 3, or a BRANCH that is not taken, is a no-op.
- FSM states: IDLE, FETCH, HOLD, HALT.
  - IDLE: imem_req = 0. If en = 1, go to FETCH next cycle.
  - FETCH: imem_req = 1, imem_addr = pc, both stable until imem_ack.
    - On ack with no pending redirect: latch instr = imem_rdata, instr_pc = pc; go to HOLD with instr_valid = 1 from the next cycle.
    - On ack with a pending redirect: discard rdata, pc = stored target, clear pending, stay in FETCH (new request the following cycle).
  - HOLD: instr_valid = 1; instr and instr_pc held stable while instr_ready = 0.
    - On instr_ready = 1: pc = pc + 4 (wraps modulo 2^XLEN); go to FETCH if en = 1, else IDLE.
  - HALT: entered on a misaligned target with ALIGN_CHECK = 1. imem_req = 0, instr_valid = 0, misalign_err = 1; stays until reset.
- Redirect handling:
  - In IDLE or HOLD: pc = target next cycle; instr_valid drops next cycle (instruction squashed); go to FETCH if en = 1, else IDLE.
  - Redirect and instr_ready in the same HOLD cycle: redirect wins, no +4.
  - In FETCH without ack: store target, set pending. Latest redirect overwrites the stored target.
  - In FETCH with ack in the same cycle: treated as pending, i.e. rdata is discarded and the target is fetched.
  - Misaligned target: HALT next cycle regardless of state. No request is issued to the bad address.
- en deassert: an in-flight FETCH completes and the instruction is held in HOLD. After acceptance, go to IDLE. en never aborts a request.
- Latency: redirect at cycle N gives imem_req with the new address at N+1 (from IDLE/HOLD). Ack at cycle M gives instr_valid at M+1.

Decomposition:
- Package t05_fetch_pkg:
  - redirect_kind_t enum (BRANCH, JAL, JALR).
  - fetch_state_t enum (IDLE, FETCH, HOLD, HALT).
  - Constant INSTR_BYTES = 4.
- One combinational sub-module, t05_target_calc: inputs kind, redirect_pc, imm, rs1_val, branch_taken; outputs target, take, misaligned, link_addr.

Test Plan:
- Reset, en = 1, memory acks every fetch after 1 cycle, instr_ready = 1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; each instr_valid 1 cycle after its ack.
- instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req = 0, pc unchanged; on release, next fetch is at instr_pc + 4.
- JAL with redirect_pc = 0x10, imm = 0x20, OFFSET_SHIFT = 0, during a FETCH with 3-cycle ack latency -> first ack discarded, next imem_addr = 0x30, link_addr = 0x14. Repeat with OFFSET_SHIFT = 2 -> 0x90.
- BRANCH with branch_taken = 0 -> no redirect. JALR with rs1_val = 0x101, imm = 0 -> target 0x100.
- JALR target 0x102 with ALIGN_CHECK = 1 -> misalign_err = 1 next cycle, FSM in HALT, no further imem_req until nRst.
- RESET_VECTOR = 0xFFFF_FFFC, one instruction accepted -> next imem_addr = 0x0000_0000 (wrap), no error. Assert nRst mid-FETCH -> imem_req = 0 immediately, pc = RESET_VECTOR.

Source files
------------

// File: rtl/t05_fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// t05_fetch_pkg
// Shared types and constants for the fetch / program-counter unit.
//   redirect_kind_t : encoding of redirect_kind (value 3 is reserved, no-op)
//   fetch_state_t   : fetch FSM state encoding
//   INSTR_BYTES     : sequential PC increment
// ---------------------------------------------------------------------------
package t05_fetch_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JAL    = 2'd1,
    JALR   = 2'd2
  } redirect_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/t05_fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// t05_fetch_pc_unit_if
// Bundles the three buses around the fetch unit:
//   imem_*     : request/ack port towards instruction memory
//   instr_*    : valid/ready port towards decode
//   redirect_* : redirect request from execute (+ link_addr back to rd write)
// master = fetch unit view, slave = environment (memory/decode/execute) view.
// ---------------------------------------------------------------------------
interface t05_fetch_pc_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;

  logic            redirect_valid;
  logic [1:0]      redirect_kind;
  logic [XLEN-1:0] redirect_pc;
  logic            branch_taken;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] link_addr;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_kind, redirect_pc, branch_taken, imm, rs1_val,
    output link_addr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_kind, redirect_pc, branch_taken, imm, rs1_val,
    input  link_addr
  );

endinterface

// File: rtl/t05_fetch_pc_unit_target_calc.sv
// ---------------------------------------------------------------------------
// t05_target_calc
// Purely combinational redirect target computation.
//   kind         in  : redirect kind (BRANCH/JAL/JALR, 3 = reserved)
//   redirect_pc  in  : pc of the redirecting instruction
//   imm          in  : sign-extended immediate
//   rs1_val      in  : rs1 value for JALR
//   branch_taken in  : ALU condition result for BRANCH
//   target       out : BRANCH/JAL: redirect_pc + (imm << OFFSET_SHIFT)
//                      JALR:       (rs1_val + imm) with bit 0 cleared
//   take         out : kind redirects (JAL, JALR, taken BRANCH)
//   misaligned   out : target[1:0] != 0
//   link_addr    out : redirect_pc + 4
// All sums wrap modulo 2^XLEN.
// ---------------------------------------------------------------------------
module t05_target_calc
  import t05_fetch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int OFFSET_SHIFT = 0
) (
  input  logic [1:0]      kind,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            branch_taken,
  output logic [XLEN-1:0] target,
  output logic            take,
  output logic            misaligned,
  output logic [XLEN-1:0] link_addr
);

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_sum;

  assign rel_sum  = redirect_pc + (imm << OFFSET_SHIFT);
  assign jalr_sum = rs1_val + imm;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can hold
    // an old value, which would otherwise infer a latch.
    target = rel_sum;
    take   = 1'b0;
    case (kind)
      BRANCH:  take = branch_taken;
      JAL:     take = 1'b1;
      JALR: begin
        take   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: take = 1'b0;
    endcase
  end

  assign misaligned = (target[1:0] != 2'b00);
  assign link_addr  = redirect_pc + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/t05_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// t05_fetch_pc_unit
// Owns the program counter, fetches one instruction at a time from
// instruction memory and holds it for decode until accepted. Redirects
// from execute are resolved here (target computed internally).
//   clk          in  : system clock, rising edge
//   nRst         in  : asynchronous active-low reset
//   en           in  : run enable; never aborts an outstanding request
//   bus          mp  : imem req/ack, decode valid/ready, redirect inputs,
//                      link_addr (see t05_fetch_pc_unit_if)
//   misalign_err out : sticky; set when a redirect targets a misaligned
//                      address with ALIGN_CHECK = 1 (unit halts until reset)
// ---------------------------------------------------------------------------
module t05_fetch_pc_unit
  import t05_fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              OFFSET_SHIFT = 0,
  parameter bit              ALIGN_CHECK  = 1'b1
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 en,
  t05_fetch_pc_unit_if.master  bus,
  output logic                 misalign_err
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_HOLD  = HOLD;
  localparam logic [1:0] ST_HALT  = HALT;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            pending;
  logic [XLEN-1:0] pend_target;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] instr_pc_q;

  logic [XLEN-1:0] calc_target;
  logic            take;
  logic            misaligned;
  logic            redirect;
  logic            redirect_bad;
  logic [XLEN-1:0] redirect_target;

  t05_target_calc #(
    .XLEN         (XLEN),
    .OFFSET_SHIFT (OFFSET_SHIFT)
  ) u_target_calc (
    .kind         (bus.redirect_kind),
    .redirect_pc  (bus.redirect_pc),
    .imm          (bus.imm),
    .rs1_val      (bus.rs1_val),
    .branch_taken (bus.branch_taken),
    .target       (calc_target),
    .take         (take),
    .misaligned   (misaligned),
    .link_addr    (bus.link_addr)
  );

  assign redirect     = bus.redirect_valid & take;
  assign redirect_bad = ALIGN_CHECK & misaligned;
  // Without alignment checking the low bits are simply dropped.
  assign redirect_target = ALIGN_CHECK ? calc_target
                                       : {calc_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= ST_IDLE;
      pc           <= RESET_VECTOR;
      pending      <= 1'b0;
      pend_target  <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      misalign_err <= 1'b0;
    end else if (state != ST_HALT && redirect && redirect_bad) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from pre-edge values regardless of statement order.
      state        <= ST_HALT;
      pending      <= 1'b0;
      misalign_err <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) pc <= redirect_target;
          if (en) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            // A redirect seen during (or on the last cycle of) the request
            // makes the returned word stale: refetch from the target.
            if (redirect) begin
              pc      <= redirect_target;
              pending <= 1'b0;
            end else if (pending) begin
              pc      <= pend_target;
              pending <= 1'b0;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= pc;
              state      <= ST_HOLD;
            end
          end else if (redirect) begin
            pending     <= 1'b1;
            pend_target <= redirect_target;
          end
        end
        ST_HOLD: begin
          // Redirect squashes the held instruction and wins over acceptance.
          if (redirect) begin
            pc    <= redirect_target;
            state <= en ? ST_FETCH : ST_IDLE;
          end else if (bus.instr_ready) begin
            pc    <= pc + XLEN'(INSTR_BYTES);
            state <= en ? ST_FETCH : ST_IDLE;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign bus.imem_req    = (state == ST_FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == ST_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_t05_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_t05_fetch_pc_unit
// dut0: default parameters (RESET_VECTOR 0, byte offsets, alignment trap).
// dut1: RESET_VECTOR 0xFFFF_FFFC, OFFSET_SHIFT 2, ALIGN_CHECK 0.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_t05_fetch_pc_unit;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic nRst;
  logic en0, en1;
  logic err0, err1;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  t05_fetch_pc_unit_if #(.XLEN(XLEN)) bus0 ();
  t05_fetch_pc_unit_if #(.XLEN(XLEN)) bus1 ();

  t05_fetch_pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0000_0000), .OFFSET_SHIFT(0), .ALIGN_CHECK(1'b1)
  ) dut0 (.clk(clk), .nRst(nRst), .en(en0), .bus(bus0.master), .misalign_err(err0));

  t05_fetch_pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'hFFFF_FFFC), .OFFSET_SHIFT(2), .ALIGN_CHECK(1'b0)
  ) dut1 (.clk(clk), .nRst(nRst), .en(en1), .bus(bus1.master), .misalign_err(err1));

  always #5 clk = ~clk;

  task automatic clear_inputs();
    en0 = 1'b0; en1 = 1'b0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = '0; bus0.instr_ready = 1'b0;
    bus0.redirect_valid = 1'b0; bus0.redirect_kind = 2'd0; bus0.redirect_pc = '0;
    bus0.branch_taken = 1'b0; bus0.imm = '0; bus0.rs1_val = '0;
    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0; bus1.instr_ready = 1'b0;
    bus1.redirect_valid = 1'b0; bus1.redirect_kind = 2'd0; bus1.redirect_pc = '0;
    bus1.branch_taken = 1'b0; bus1.imm = '0; bus1.rs1_val = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
  endtask

  // Waits for a dut0 request, checks its address, acks after lat idle cycles,
  // then checks the instruction presented to decode the cycle after the ack.
  task automatic fetch_one(input int lat, input logic [31:0] data,
                           input logic [XLEN-1:0] want_addr, input string tag);
    int n = 0;
    while (bus0.imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    cmp_cnt++;
    if (bus0.imem_req !== 1'b1) begin
      mis_cnt++; $display("FAIL %s_req_timeout: imem_req got %b want 1", tag, bus0.imem_req); return;
    end
    cmp_cnt++;
    if (bus0.imem_addr !== want_addr) begin
      mis_cnt++; $display("FAIL %s_addr: got %h want %h", tag, bus0.imem_addr, want_addr);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== want_addr) begin
        mis_cnt++; $display("FAIL %s_req_stable: req %b addr %h want 1 %h", tag, bus0.imem_req, bus0.imem_addr, want_addr);
      end
    end
    bus0.imem_ack = 1'b1; bus0.imem_rdata = data;
    @(negedge clk);
    bus0.imem_ack = 1'b0;
    cmp_cnt++;
    if (bus0.instr_valid !== 1'b1 || bus0.instr !== data || bus0.instr_pc !== want_addr) begin
      mis_cnt++; $display("FAIL %s_instr: valid %b instr %h pc %h want 1 %h %h", tag, bus0.instr_valid, bus0.instr, bus0.instr_pc, data, want_addr);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++;
    if (bus0.imem_req !== 1'b0 || bus0.instr_valid !== 1'b0 || err0 !== 1'b0) begin
      mis_cnt++; $display("FAIL reset_ctrl0: req %b valid %b err %b want 0 0 0", bus0.imem_req, bus0.instr_valid, err0);
    end
    cmp_cnt++;
    if (bus0.instr !== 32'h0 || bus0.instr_pc !== 32'h0 || bus0.imem_addr !== 32'h0) begin
      mis_cnt++; $display("FAIL reset_data0: instr %h pc %h addr %h want 0 0 0", bus0.instr, bus0.instr_pc, bus0.imem_addr);
    end
    cmp_cnt++;
    if (bus1.imem_addr !== 32'hFFFF_FFFC || bus1.imem_req !== 1'b0) begin
      mis_cnt++; $display("FAIL reset_vec1: addr %h req %b want fffffffc 0", bus1.imem_addr, bus1.imem_req);
    end
    // en low: the unit must stay idle.
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (bus0.imem_req !== 1'b0) begin
      mis_cnt++; $display("FAIL idle_no_req: got %b want 0", bus0.imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    en0 = 1'b1; bus0.instr_ready = 1'b1;
    fetch_one(1, 32'h1111_0001, 32'h0, "seq0");
    fetch_one(1, 32'h2222_0002, 32'h4, "seq1");
    fetch_one(1, 32'h3333_0003, 32'h8, "seq2");
  endtask

  task automatic test_stall();
    do_reset();
    en0 = 1'b1; bus0.instr_ready = 1'b0;
    fetch_one(0, 32'hCAFE_0000, 32'h0, "stall_fetch");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (bus0.instr_valid !== 1'b1 || bus0.instr !== 32'hCAFE_0000 || bus0.instr_pc !== 32'h0
          || bus0.imem_req !== 1'b0 || bus0.imem_addr !== 32'h0) begin
        mis_cnt++; $display("FAIL stall_hold: valid %b instr %h pc %h req %b addr %h want 1 cafe0000 0 0 0",
                            bus0.instr_valid, bus0.instr, bus0.instr_pc, bus0.imem_req, bus0.imem_addr);
      end
    end
    bus0.instr_ready = 1'b1;
    @(negedge clk);
    bus0.instr_ready = 1'b0;
    fetch_one(0, 32'hCAFE_0004, 32'h4, "stall_next");
  endtask

  task automatic test_jal();
    int n = 0;
    do_reset();
    en0 = 1'b1; bus0.instr_ready = 1'b1;
    while (bus0.imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    cmp_cnt++;
    if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin
      mis_cnt++; $display("FAIL jal_first_req: req %b addr %h want 1 0", bus0.imem_req, bus0.imem_addr);
    end
    bus0.redirect_valid = 1'b1; bus0.redirect_kind = 2'd1;
    bus0.redirect_pc = 32'h10; bus0.imm = 32'h20;
    #1;
    cmp_cnt++;
    if (bus0.link_addr !== 32'h14) begin
      mis_cnt++; $display("FAIL jal_link: got %h want 00000014", bus0.link_addr);
    end
    @(negedge clk);
    bus0.redirect_valid = 1'b0;
    @(negedge clk);
    bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus0.imem_ack = 1'b0;
    cmp_cnt++;
    if (bus0.instr_valid !== 1'b0 || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h30) begin
      mis_cnt++; $display("FAIL jal_discard: valid %b req %b addr %h want 0 1 00000030", bus0.instr_valid, bus0.imem_req, bus0.imem_addr);
    end
    fetch_one(0, 32'hA0A0_0030, 32'h30, "jal_target");
  endtask

  task automatic test_branch_jalr();
    do_reset();
    en0 = 1'b1; bus0.instr_ready = 1'b0;
    fetch_one(0, 32'hB0B0_0000, 32'h0, "br_fetch");
    // Not-taken branch: no-op, instruction stays held.
    bus0.redirect_valid = 1'b1; bus0.redirect_kind = 2'd0; bus0.branch_taken = 1'b0;
    bus0.redirect_pc = 32'h40; bus0.imm = 32'h80;
    @(negedge clk);
    cmp_cnt++;
    if (bus0.instr_valid !== 1'b1 || bus0.instr_pc !== 32'h0 || bus0.imem_req !== 1'b0) begin
      mis_cnt++; $display("FAIL br_not_taken: valid %b pc %h req %b want 1 0 0", bus0.instr_valid, bus0.instr_pc, bus0.imem_req);
    end
    // Reserved kind 3 is also a no-op.
    bus0.redirect_kind = 2'd3;
    @(negedge clk);
    cmp_cnt++;
    if (bus0.instr_valid !== 1'b1 || bus0.imem_req !== 1'b0) begin
      mis_cnt++; $display("FAIL kind3_noop: valid %b req %b want 1 0", bus0.instr_valid, bus0.imem_req);
    end
    // JALR together with instr_ready: redirect wins, no +4.
    bus0.redirect_kind = 2'd2; bus0.rs1_val = 32'h101; bus0.imm = 32'h0;
    bus0.instr_ready = 1'b1;
    @(negedge clk);
    bus0.redirect_valid = 1'b0; bus0.instr_ready = 1'b0;
    cmp_cnt++;
    if (bus0.instr_valid !== 1'b0 || bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h100 || err0 !== 1'b0) begin
      mis_cnt++; $display("FAIL jalr_target: valid %b req %b addr %h err %b want 0 1 00000100 0",
                          bus0.instr_valid, bus0.imem_req, bus0.imem_addr, err0);
    end
  endtask

  task automatic test_misalign();
    int seen_req = 0;
    do_reset();
    en0 = 1'b1; bus0.instr_ready = 1'b0;
    fetch_one(0, 32'hC0C0_0000, 32'h0, "mis_fetch");
    bus0.redirect_valid = 1'b1; bus0.redirect_kind = 2'd2; bus0.rs1_val = 32'h102; bus0.imm = 32'h0;
    @(negedge clk);
    bus0.redirect_valid = 1'b0;
    cmp_cnt++;
    if (err0 !== 1'b1 || bus0.imem_req !== 1'b0 || bus0.instr_valid !== 1'b0) begin
      mis_cnt++; $display("FAIL misalign_halt: err %b req %b valid %b want 1 0 0", err0, bus0.imem_req, bus0.instr_valid);
    end
    bus0.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.imem_req !== 1'b0 || bus0.instr_valid !== 1'b0 || err0 !== 1'b1) seen_req++;
    end
    cmp_cnt++;
    if (seen_req != 0) begin
      mis_cnt++; $display("FAIL halt_sticky: bad cycles %0d want 0", seen_req);
    end
    do_reset();
    cmp_cnt++;
    if (err0 !== 1'b0) begin
      mis_cnt++; $display("FAIL misalign_clear: err %b want 0", err0);
    end
  endtask

  task automatic test_dut1();
    int n = 0;
    do_reset();
    en1 = 1'b1; bus1.instr_ready = 1'b1;
    while (bus1.imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    cmp_cnt++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hFFFF_FFFC) begin
      mis_cnt++; $display("FAIL wrap_first: req %b addr %h want 1 fffffffc", bus1.imem_req, bus1.imem_addr);
    end
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    cmp_cnt++;
    if (bus1.instr_valid !== 1'b1 || bus1.instr_pc !== 32'hFFFF_FFFC || bus1.instr !== 32'h5555_AAAA) begin
      mis_cnt++; $display("FAIL wrap_instr: valid %b pc %h instr %h want 1 fffffffc 5555aaaa", bus1.instr_valid, bus1.instr_pc, bus1.instr);
    end
    @(negedge clk);
    cmp_cnt++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h0 || err1 !== 1'b0) begin
      mis_cnt++; $display("FAIL wrap_next: req %b addr %h err %b want 1 0 0", bus1.imem_req, bus1.imem_addr, err1);
    end
    // JAL with word offsets: 0x10 + (0x20 << 2).
    bus1.redirect_valid = 1'b1; bus1.redirect_kind = 2'd1; bus1.redirect_pc = 32'h10; bus1.imm = 32'h20;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    @(negedge clk);
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    cmp_cnt++;
    if (bus1.instr_valid !== 1'b0 || bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h90) begin
      mis_cnt++; $display("FAIL jal_shift2: valid %b req %b addr %h want 0 1 00000090", bus1.instr_valid, bus1.imem_req, bus1.imem_addr);
    end
    bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h9090_9090; bus1.instr_ready = 1'b0;
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    cmp_cnt++;
    if (bus1.instr_valid !== 1'b1 || bus1.instr_pc !== 32'h90) begin
      mis_cnt++; $display("FAIL jal_shift2_instr: valid %b pc %h want 1 00000090", bus1.instr_valid, bus1.instr_pc);
    end
    // No alignment trap: low bits of 0x102 are dropped to give 0x100.
    bus1.redirect_valid = 1'b1; bus1.redirect_kind = 2'd2; bus1.rs1_val = 32'h102; bus1.imm = 32'h0;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    cmp_cnt++;
    if (err1 !== 1'b0 || bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h100 || bus1.instr_valid !== 1'b0) begin
      mis_cnt++; $display("FAIL noalign_force: err %b req %b addr %h valid %b want 0 1 00000100 0",
                          err1, bus1.imem_req, bus1.imem_addr, bus1.instr_valid);
    end
    // Reset in the middle of a fetch drops the request at once.
    #2 nRst = 1'b0;
    #1;
    cmp_cnt++;
    if (bus1.imem_req !== 1'b0 || bus1.imem_addr !== 32'hFFFF_FFFC || bus1.instr_valid !== 1'b0) begin
      mis_cnt++; $display("FAIL async_reset: req %b addr %h valid %b want 0 fffffffc 0", bus1.imem_req, bus1.imem_addr, bus1.instr_valid);
    end
    @(negedge clk);
    nRst = 1'b1;
  endtask

  // Random traffic against a handshake-level reference: fetch addresses form
  // the architectural stream (sequential +4 on acceptance, jump on redirect),
  // a redirect during a request makes that request's data stale, and each
  // delivered word must equal what memory returned for that address.
  task automatic test_random();
    logic exp_req = 1'b0, exp_valid = 1'b0, req_active = 1'b0, discard = 1'b0;
    logic [31:0] exp_addr = '0, req_addr = '0, exp_instr = '0, exp_ipc = '0;
    logic n_req, n_valid, rv, tk, eff, ack, rdy, e;
    logic [1:0] kind;
    logic [31:0] rpc, imm, rs1, tgt, rd;
    int accepted = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cmp_cnt++;
      if (bus0.imem_req !== exp_req || bus0.instr_valid !== exp_valid) begin
        mis_cnt++; $display("FAIL rnd_ctrl cyc %0d: req %b valid %b want %b %b", cyc, bus0.imem_req, bus0.instr_valid, exp_req, exp_valid);
      end
      if (exp_valid) begin
        cmp_cnt++;
        if (bus0.instr !== exp_instr || bus0.instr_pc !== exp_ipc) begin
          mis_cnt++; $display("FAIL rnd_instr cyc %0d: instr %h pc %h want %h %h", cyc, bus0.instr, bus0.instr_pc, exp_instr, exp_ipc);
        end
      end
      if (exp_req) begin
        if (!req_active) begin
          req_active = 1'b1; req_addr = exp_addr;
        end
        cmp_cnt++;
        if (bus0.imem_addr !== req_addr) begin
          mis_cnt++; $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, bus0.imem_addr, req_addr);
        end
      end
      e    = ($urandom_range(0, 7) != 0);
      rdy  = 1'($urandom_range(0, 1));
      ack  = exp_req && ($urandom_range(0, 2) == 0);
      rd   = $urandom();
      rv   = ($urandom_range(0, 9) == 0);
      kind = 2'($urandom_range(0, 3));
      tk   = 1'($urandom_range(0, 1));
      rpc  = $urandom() & 32'hFFFF_FFFC;
      imm  = $urandom() & 32'hFFFF_FFFC;
      rs1  = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      eff  = 1'b0; tgt = '0;
      if (rv) begin
        case (kind)
          2'd0: if (tk) begin eff = 1'b1; tgt = rpc + imm; end
          2'd1: begin eff = 1'b1; tgt = rpc + imm; end
          2'd2: begin eff = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
          default: eff = 1'b0;
        endcase
      end
      en0 = e; bus0.instr_ready = rdy; bus0.imem_ack = ack; bus0.imem_rdata = rd;
      bus0.redirect_valid = rv; bus0.redirect_kind = kind; bus0.branch_taken = tk;
      bus0.redirect_pc = rpc; bus0.imm = imm; bus0.rs1_val = rs1;
      if (exp_req) begin
        if (eff) exp_addr = tgt;
        if (ack) begin
          req_active = 1'b0;
          if (discard || eff) begin
            discard = 1'b0; n_req = 1'b1; n_valid = 1'b0;
          end else begin
            n_req = 1'b0; n_valid = 1'b1; exp_instr = rd; exp_ipc = req_addr;
          end
        end else begin
          if (eff) discard = 1'b1;
          n_req = 1'b1; n_valid = 1'b0;
        end
      end else if (exp_valid) begin
        if (eff) begin
          exp_addr = tgt; n_req = e; n_valid = 1'b0;
        end else if (rdy) begin
          exp_addr = exp_ipc + 32'd4; n_req = e; n_valid = 1'b0; accepted++;
        end else begin
          n_req = 1'b0; n_valid = 1'b1;
        end
      end else begin
        if (eff) exp_addr = tgt;
        n_req = e; n_valid = 1'b0;
      end
      exp_req = n_req; exp_valid = n_valid;
      @(negedge clk);
    end
    clear_inputs();
    cmp_cnt++;
    if (err0 !== 1'b0 || accepted == 0) begin
      mis_cnt++; $display("FAIL rnd_end: err %b accepted %0d want 0 >0", err0, accepted);
    end
  endtask

  initial begin
    clear_inputs();
    nRst = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_jal();
    test_branch_jalr();
    test_misalign();
    test_dut1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  // Absolute time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
